// File: rtl/alu_exec_stage.sv
// -----------------------------------------------------------------------------
// alu_exec_stage: registered execute stage around a 32-bit combinational alu.
//
// Build option: define ALU_EXEC_SKID_EN to register in_ready and add a
// one-entry skid buffer. This removes the combinational out_ready -> in_ready
// path and raises capacity to two ops. Throughput stays at 1 op/cycle.
//
// Handshake (both sides): a beat moves on a rising clk edge where
// valid && ready. valid, once raised by a producer, holds with stable payload
// until it is accepted. ready may change freely.
//
// alu opcode map (aluc). carry and overflow are 0 unless listed:
//   0000 addu  a+b           carry = unsigned carry out
//   0001 subu  a-b           carry = borrow (a < b unsigned)
//   0010 add   a+b           carry = carry out, overflow = signed overflow
//   0011 sub   a-b           carry = borrow,    overflow = signed overflow
//   0100 and   0101 or   0110 xor   0111 nor
//   100x lui   {b[15:0], 16'h0}
//   1010 sltu  a < b unsigned, carry = borrow
//   1011 slt   a < b signed
//   1100 sra   b >>> a[4:0]
//   1101 srl   b >> a[4:0]
//   111x sll   b << a[4:0]
//   zero = (result == 0), negative = result[31]
//
// Ports (alu_exec_stage):
//   clk, rst         rising-edge clock, asynchronous active-high reset
//   in_valid/ready   upstream handshake; in_a, in_b, in_aluc, in_tag payload
//   out_valid/ready  downstream handshake; out_result, out_flags
//                    {zero, carry, negative, overflow}, out_tag payload
//   sticky_flags     {carry, overflow} ORed over output transfers
//   clr_sticky       pulse that clears sticky_flags (a same-cycle transfer
//                    still contributes its flags)
//   op_count         completed output transfers, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------

module alu (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  aluc,
  output logic [31:0] r,
  output logic        zero,
  output logic        carry,
  output logic        negative,
  output logic        overflow
);

  // 33-bit add/sub. Bit 32 is the carry out, or the borrow for subtraction.
  logic [32:0] sum;
  logic [32:0] dif;
  logic        add_ovf;
  logic        sub_ovf;

  assign sum = {1'b0, a} + {1'b0, b};
  assign dif = {1'b0, a} - {1'b0, b};

  // Signed overflow: same-sign operands give a result of the other sign
  // (add), or different-sign operands give a result whose sign differs
  // from a (sub).
  assign add_ovf = (a[31] == b[31]) && (sum[31] != a[31]);
  assign sub_ovf = (a[31] != b[31]) && (dif[31] != a[31]);

  always_comb begin
    r        = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    case (aluc)
      4'b0000: begin r = sum[31:0]; carry = sum[32]; end
      4'b0001: begin r = dif[31:0]; carry = dif[32]; end
      4'b0010: begin r = sum[31:0]; carry = sum[32]; overflow = add_ovf; end
      4'b0011: begin r = dif[31:0]; carry = dif[32]; overflow = sub_ovf; end
      4'b0100: r = a & b;
      4'b0101: r = a | b;
      4'b0110: r = a ^ b;
      4'b0111: r = ~(a | b);
      4'b1000,
      4'b1001: r = {b[15:0], 16'h0000};
      4'b1010: begin r = {31'b0, dif[32]}; carry = dif[32]; end
      4'b1011: r = {31'b0, ($signed(a) < $signed(b))};
      4'b1100: r = $signed(b) >>> a[4:0];
      4'b1101: r = b >> a[4:0];
      default: r = b << a[4:0];   // 1110, 1111
    endcase
  end

  assign zero     = (r == 32'h0);
  assign negative = r[31];

endmodule

module alu_exec_stage #(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [3:0]       in_aluc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [3:0]       out_flags,
  output logic [TAG_W-1:0] out_tag,
  output logic [1:0]       sticky_flags,
  input  logic             clr_sticky,
  output logic [CNT_W-1:0] op_count
);

  // Operands presented to the alu. They come from the skid entry when one
  // is held, otherwise straight from the input port.
  logic [31:0]      alu_a;
  logic [31:0]      alu_b;
  logic [3:0]       alu_aluc;
  logic [TAG_W-1:0] load_tag;

  logic [31:0]      alu_r;
  logic             alu_zero;
  logic             alu_carry;
  logic             alu_negative;
  logic             alu_overflow;

  logic             in_fire;
  logic             out_fire;
  logic             load;       // output register captures alu outputs

  assign out_fire = out_valid && out_ready;

`ifdef ALU_EXEC_SKID_EN
  logic             skid_valid;
  logic             skid_valid_next;
  logic [31:0]      skid_a;
  logic [31:0]      skid_b;
  logic [3:0]       skid_aluc;
  logic [TAG_W-1:0] skid_tag;
  logic             ready_q;
  logic             load_ok;
  logic             skid_capture;

  // Output register is free this cycle: empty, or its value is leaving.
  assign load_ok  = !out_valid || out_ready;
  assign in_ready = ready_q;
  assign in_fire  = in_valid && ready_q;

  // The skid entry is older than anything on the port, so it loads first.
  // in_ready is low while the entry is full, so both cannot compete.
  assign load         = (skid_valid || in_fire) && load_ok;
  assign skid_capture = in_fire && !load_ok;

  assign alu_a    = skid_valid ? skid_a    : in_a;
  assign alu_b    = skid_valid ? skid_b    : in_b;
  assign alu_aluc = skid_valid ? skid_aluc : in_aluc;
  assign load_tag = skid_valid ? skid_tag  : in_tag;

  always_comb begin
    skid_valid_next = skid_valid;
    if (skid_valid) begin
      if (load_ok) skid_valid_next = 1'b0;
    end else if (skid_capture) begin
      skid_valid_next = 1'b1;
    end
  end

  // ready_q resets low and rises on the first edge after reset releases.
  // It depends only on flop state, never on out_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_valid <= 1'b0;
      skid_a     <= '0;
      skid_b     <= '0;
      skid_aluc  <= '0;
      skid_tag   <= '0;
      ready_q    <= 1'b0;
    end else begin
      skid_valid <= skid_valid_next;
      ready_q    <= !skid_valid_next;
      if (skid_capture) begin
        skid_a    <= in_a;
        skid_b    <= in_b;
        skid_aluc <= in_aluc;
        skid_tag  <= in_tag;
      end
    end
  end
`else
  // Capacity of one op. Accept whenever the output register is empty or
  // is being emptied in this same cycle. Held low during reset.
  assign in_ready = !rst && (!out_valid || out_ready);
  assign in_fire  = in_valid && in_ready;
  assign load     = in_fire;

  assign alu_a    = in_a;
  assign alu_b    = in_b;
  assign alu_aluc = in_aluc;
  assign load_tag = in_tag;
`endif

  // The opcode passes straight through. This stage does no decoding.
  alu u_alu (
    .a        (alu_a),
    .b        (alu_b),
    .aluc     (alu_aluc),
    .r        (alu_r),
    .zero     (alu_zero),
    .carry    (alu_carry),
    .negative (alu_negative),
    .overflow (alu_overflow)
  );

  // Output register. It holds steady while stalled (out_valid && !out_ready).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_flags  <= '0;
      out_tag    <= '0;
    end else if (load) begin
      out_valid  <= 1'b1;
      out_result <= alu_r;
      out_flags  <= {alu_zero, alu_carry, alu_negative, alu_overflow};
      out_tag    <= load_tag;
    end else if (out_fire) begin
      out_valid  <= 1'b0;
    end
  end

  // Sticky {carry, overflow}. A clear that coincides with a transfer
  // leaves exactly that transfer's flags: the clear applies first, then
  // the transfer's flags are ORed in.
  logic [1:0] xfer_flags;
  assign xfer_flags = {out_flags[2], out_flags[0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_flags <= 2'b00;
    end else if (clr_sticky) begin
      sticky_flags <= out_fire ? xfer_flags : 2'b00;
    end else if (out_fire) begin
      sticky_flags <= sticky_flags | xfer_flags;
    end
  end

  // Completed-operation counter. It wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count <= '0;
    end else if (out_fire) begin
      op_count <= op_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_exec_stage: directed plus random bench for alu_exec_stage.
// The main instance uses CNT_W=16. A second instance with CNT_W=4 shares the
// same inputs so that counter wrap can be observed. Expected results come
// from an independent alu model. They are queued when an input beat is
// accepted and compared when the matching output beat leaves.
// -----------------------------------------------------------------------------

module tb_alu_exec_stage;

  localparam int TAG_W = 4;
  localparam int W     = 36 + TAG_W;   // {flags, result, tag}
`ifdef ALU_EXEC_SKID_EN
  localparam int BP_ACC = 2;
`else
  localparam int BP_ACC = 1;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic             in_valid   = 1'b0;
  logic [31:0]      in_a       = '0;
  logic [31:0]      in_b       = '0;
  logic [3:0]       in_aluc    = '0;
  logic [TAG_W-1:0] in_tag     = '0;
  logic             out_ready  = 1'b1;
  logic             clr_sticky = 1'b0;

  logic             in_ready;
  logic             out_valid;
  logic [31:0]      out_result;
  logic [3:0]       out_flags;
  logic [TAG_W-1:0] out_tag;
  logic [1:0]       sticky_flags;
  logic [15:0]      op_count;

  logic             s_in_ready;
  logic             s_out_valid;
  logic [31:0]      s_out_result;
  logic [3:0]       s_out_flags;
  logic [TAG_W-1:0] s_out_tag;
  logic [1:0]       s_sticky_flags;
  logic [3:0]       s_op_count;

  alu_exec_stage #(.TAG_W(TAG_W), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_aluc(in_aluc), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags), .out_tag(out_tag),
    .sticky_flags(sticky_flags), .clr_sticky(clr_sticky), .op_count(op_count)
  );

  alu_exec_stage #(.TAG_W(TAG_W), .CNT_W(4)) u_dut_w4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(s_in_ready),
    .in_a(in_a), .in_b(in_b), .in_aluc(in_aluc), .in_tag(in_tag),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .out_result(s_out_result), .out_flags(s_out_flags), .out_tag(s_out_tag),
    .sticky_flags(s_sticky_flags), .clr_sticky(clr_sticky), .op_count(s_op_count)
  );

  // ---------------- scoreboard state ----------------
  int             n_checks = 0;
  int             n_fail   = 0;
  logic [W-1:0]   exp_q[$];
  logic [W-1:0]   mon_exp;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference alu, written from the opcode table. Returns {flags, result}.
  function automatic logic [35:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
    logic [31:0] r;
    logic        c;
    logic        v;
    logic [63:0] u;
    longint      sa;
    longint      sb;
    longint      ss;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = '0; c = 1'b0; v = 1'b0; u = '0; ss = 0;
    case (op)
      4'd0:  begin u = {32'b0, a} + {32'b0, b}; r = u[31:0]; c = u[32]; end
      4'd1:  begin r = a - b; c = (a < b); end
      4'd2:  begin
               u = {32'b0, a} + {32'b0, b}; r = u[31:0]; c = u[32];
               ss = sa + sb;
               v = (ss > longint'(32'sh7fffffff)) || (ss < longint'(32'sh80000000));
             end
      4'd3:  begin
               r = a - b; c = (a < b);
               ss = sa - sb;
               v = (ss > longint'(32'sh7fffffff)) || (ss < longint'(32'sh80000000));
             end
      4'd4:  r = a & b;
      4'd5:  r = a | b;
      4'd6:  r = a ^ b;
      4'd7:  r = ~(a | b);
      4'd8, 4'd9: r = {b[15:0], 16'h0};
      4'd10: begin c = (a < b); r = {31'b0, c}; end
      4'd11: r = (sa < sb) ? 32'd1 : 32'd0;
      4'd12: r = $signed(b) >>> a[4:0];
      4'd13: r = b >> a[4:0];
      default: r = b << a[4:0];
    endcase
    return {(r == 32'h0), c, r[31], v, r};
  endfunction

  // Monitor on the falling edge: pop/compare for an output beat, then queue
  // the expectation for an input beat (the output beat is always older).
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 64'd1, 64'd0);
        end else begin
          mon_exp = exp_q.pop_front();
          check("result", 64'({out_flags, out_result, out_tag}), 64'(mon_exp));
        end
      end
      if (in_valid && in_ready)
        exp_q.push_back({alu_ref(in_a, in_b, in_aluc), in_tag});
    end
  end

  // ---------------- driver ----------------
  // Offer one op and return #1 after the edge that accepted it.
  task automatic send_op(input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op, input logic [TAG_W-1:0] tag);
    logic accepted;
    int   n;
    accepted = 1'b0;
    n = 0;
    in_valid = 1'b1; in_a = a; in_b = b; in_aluc = op; in_tag = tag;
    while (!accepted && n < 200) begin
      @(negedge clk);
      accepted = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!accepted) check("accept_timeout", 64'd0, 64'd1);
  endtask

  // ---------------- directed sequence ----------------
  int           start_cyc;
  int           acc;
  int           idx;
  logic [W-1:0] held;

  initial begin
    // Reset state, applied asynchronously between edges.
    #1 rst = 1'b1;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_result", 64'(out_result), 64'd0);
    check("rst_out_flags", 64'(out_flags), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("rst_sticky", 64'(sticky_flags), 64'd0);
    check("rst_op_count", 64'(op_count), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Single ADD with signed overflow.
    out_ready = 1'b1;
    send_op(32'h7fffffff, 32'h1, 4'b0010, 4'd3);
    check("single_valid", 64'(out_valid), 64'd1);
    check("single_result", 64'(out_result), 64'h80000000);
    check("single_flags", 64'(out_flags), 64'b0011);
    check("single_tag", 64'(out_tag), 64'd3);
    @(posedge clk); #1;
    check("single_drained", 64'(out_valid), 64'd0);
    check("single_count", 64'(op_count), 64'd1);

    // Sticky flags: a clear with no transfer, then carry, then clear + overflow.
    check("sticky_after_add", 64'(sticky_flags), 64'b01);
    clr_sticky = 1'b1; @(posedge clk); #1; clr_sticky = 1'b0;
    check("sticky_cleared", 64'(sticky_flags), 64'b00);
    send_op(32'hffffffff, 32'h1, 4'b0000, 4'd5);
    send_op(32'h7fffffff, 32'h1, 4'b0010, 4'd6);
    check("sticky_carry", 64'(sticky_flags), 64'b10);
    clr_sticky = 1'b1; @(posedge clk); #1; clr_sticky = 1'b0;
    check("sticky_clr_with_xfer", 64'(sticky_flags), 64'b01);

    // Backpressure: stall the output for 5 cycles while offering 3 ops.
    out_ready = 1'b0;
    acc = 0; idx = 0; held = '0;
    for (int c = 0; c < 5; c++) begin
      in_valid = (idx < 3);
      in_a = 32'h10 + 32'(idx); in_b = 32'h3;
      in_aluc = 4'(idx + 4); in_tag = TAG_W'(8 + idx);
      @(negedge clk);
      if (in_valid && in_ready) begin acc++; idx++; end
      @(posedge clk); #1;
      if (c == 0) held = {out_flags, out_result, out_tag};
      else check("bp_stable", 64'({out_flags, out_result, out_tag}), 64'(held));
    end
    in_valid = 1'b0;
    check("bp_accepted", 64'(acc), 64'(BP_ACC));
    check("bp_valid_held", 64'(out_valid), 64'd1);
    check("bp_in_ready_low", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    for (int k = acc; k < 3; k++)
      send_op(32'h10 + 32'(k), 32'h3, 4'(k + 4), TAG_W'(8 + k));
    repeat (3) @(posedge clk);
    #1;
    check("bp_queue_empty", 64'(exp_q.size()), 64'd0);
    check("bp_out_idle", 64'(out_valid), 64'd0);
    check("bp_count", 64'(op_count), 64'd6);

    // Reset while a result is held and stalled.
    out_ready = 1'b0;
    send_op(32'h5, 32'h7, 4'b0000, 4'hc);
    check("mid_pre_valid", 64'(out_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_result", 64'(out_result), 64'd0);
    check("mid_rst_flags", 64'(out_flags), 64'd0);
    check("mid_rst_tag", 64'(out_tag), 64'd0);
    check("mid_rst_sticky", 64'(sticky_flags), 64'd0);
    check("mid_rst_count", 64'(op_count), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #2 rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("mid_post_in_ready", 64'(in_ready), 64'd1);
    check("mid_post_valid", 64'(out_valid), 64'd0);

    // Streaming: 100 random ops, one accepted per cycle.
    start_cyc = cyc;
    for (int i = 0; i < 100; i++)
      send_op($urandom, $urandom, 4'($urandom_range(0, 15)), TAG_W'(i));
    check("stream_cycles", 64'(cyc - start_cyc), 64'd100);
    @(posedge clk); #1;
    check("stream_count", 64'(op_count), 64'd100);
    check("stream_count_w4", 64'(s_op_count), 64'd4);
    check("stream_queue_empty", 64'(exp_q.size()), 64'd0);

    // Counter wrap on the 4-bit instance: 17 transfers after reset.
    rst = 1'b1;
    #1 rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 17; i++)
      send_op(32'(i), 32'h1, 4'b0000, TAG_W'(i));
    @(posedge clk); #1;
    check("wrap_count_w4", 64'(s_op_count), 64'd1);
    check("wrap_count_w16", 64'(op_count), 64'd17);
    check("wrap_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
